// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: memory-mapped IO block for the 3-stage RISC-V core.
// Provides registered read data, RX/TX byte FIFOs toward the UART, and
// clearable cycle/instruction counters. Selected by the core when
// addr[31:30] == 2'b10; only io_addr[4:2] is decoded here.
// Optional build macro IO_BRANCH_STATS_EN adds branch_commit/branch_taken
// inputs and BR_TOTAL (0x1C) / BR_TAKEN (0x0C) counters.
module io_mmio_ctrl #(
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        instr_commit,
`ifdef IO_BRANCH_STATS_EN
    input  logic        branch_commit,
    input  logic        branch_taken,
`endif
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

    typedef enum logic [2:0] {
        OFF_STATUS   = 3'd0,
        OFF_RX_DATA  = 3'd1,
        OFF_TX_DATA  = 3'd2,
        OFF_BR_TAKEN = 3'd3,
        OFF_CYCLE    = 3'd4,
        OFF_INSTR    = 3'd5,
        OFF_CNT_RST  = 3'd6,
        OFF_BR_TOTAL = 3'd7
    } io_off_e;

    io_off_e off;
    assign off = io_off_e'(io_addr[4:2]);

    // Only word offsets and the low write byte are meaningful here.
    logic unused_bits;
    assign unused_bits = ^{io_addr[31:5], io_addr[1:0], io_wdata[31:8]};

    // ---------------- FIFO state ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wp, rx_rp;
    logic [RX_AW:0] rx_cnt;
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wp, tx_rp;
    logic [TX_AW:0] tx_cnt;
    logic           tx_ovf, rx_ovf;

    logic rx_not_empty, tx_not_full;
    logic rx_push, rx_pop, rx_udf;
    logic tx_req, tx_push, tx_pop, tx_drop;
    logic sts_clr, cnt_clr;

    assign rx_not_empty  = (rx_cnt != '0);
    assign tx_not_full   = (tx_cnt != TX_FULL);
    assign uart_rx_ready = (rx_cnt != RX_FULL);
    assign uart_tx_valid = (tx_cnt != '0);
    assign uart_tx_data  = tx_mem[tx_rp];

    assign rx_push = uart_rx_valid && uart_rx_ready;
    assign rx_pop  = io_re && (off == OFF_RX_DATA) && rx_not_empty;
    assign rx_udf  = io_re && (off == OFF_RX_DATA) && !rx_not_empty;

    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when the transmitter takes the head.
    assign tx_pop  = uart_tx_valid && uart_tx_ready;
    assign tx_req  = io_we && (off == OFF_TX_DATA);
    assign tx_push = tx_req && (tx_not_full || tx_pop);
    assign tx_drop = tx_req && !tx_not_full && !tx_pop;

    assign sts_clr = io_we && (off == OFF_STATUS);
    assign cnt_clr = io_we && (off == OFF_CNT_RST);

    // FIFO storage writes.
    // NOTE: the storage arrays have no reset; pointers and counts alone
    // define what is valid, and a reset-free array can map onto RAM.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
        if (tx_push) tx_mem[tx_wp] <= io_wdata[7:0];
    end

    // FIFO pointers, occupancy counts and sticky error flags.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register in the block sees pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RX_AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (RX_AW+1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (RX_AW+1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase

            if (tx_push) tx_wp <= tx_wp + TX_AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TX_AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (TX_AW+1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (TX_AW+1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase

            // Clear and set never coincide: they need different offsets.
            if (sts_clr) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_drop) tx_ovf <= 1'b1;
            if (rx_udf)  rx_ovf <= 1'b1;
        end
    end

    // ---------------- counters ----------------
    logic [CNT_W-1:0] cyc_cnt, ins_cnt;
`ifdef IO_BRANCH_STATS_EN
    logic [CNT_W-1:0] br_total, br_taken;
`endif

    // Free-running cycle and retired-instruction counters; CNT_RST wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
`ifdef IO_BRANCH_STATS_EN
            br_total <= '0;
            br_taken <= '0;
`endif
        end else if (cnt_clr) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
`ifdef IO_BRANCH_STATS_EN
            br_total <= '0;
            br_taken <= '0;
`endif
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (instr_commit) ins_cnt <= ins_cnt + CNT_W'(1);
`ifdef IO_BRANCH_STATS_EN
            if (branch_commit)                 br_total <= br_total + CNT_W'(1);
            if (branch_commit && branch_taken) br_taken <= br_taken + CNT_W'(1);
`endif
        end
    end

    // ---------------- read path ----------------
    logic [31:0] rd_mux;

    // Read mux over pre-edge state; counters zero-extend or truncate to 32.
    // NOTE: rd_mux gets a default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_STATUS:   rd_mux = {28'd0, rx_ovf, tx_ovf, rx_not_empty, tx_not_full};
            OFF_RX_DATA:  if (rx_not_empty) rd_mux = {24'd0, rx_mem[rx_rp]};
            OFF_CYCLE:    rd_mux = 32'(cyc_cnt);
            OFF_INSTR:    rd_mux = 32'(ins_cnt);
`ifdef IO_BRANCH_STATS_EN
            OFF_BR_TAKEN: rd_mux = 32'(br_taken);
            OFF_BR_TOTAL: rd_mux = 32'(br_total);
`endif
            default:      rd_mux = '0;
        endcase
    end

    // Registered read data, updated only on a read and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_rdata <= '0;
        end else if (io_re) begin
            io_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Self-checking bench for io_mmio_ctrl, built with CNT_W=8 so counter wrap
// is reachable quickly. Read and TX expectations flow through queues.
`timescale 1ns/1ps
module tb_io_mmio_ctrl;

    localparam int RXD = 8;
    localparam int TXD = 8;
    localparam int CW  = 8;

    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_OFF3   = 32'h8000_000C;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] A_INSTR  = 32'h8000_0014;
    localparam logic [31:0] A_CNTRST = 32'h8000_0018;
    localparam logic [31:0] A_OFF7   = 32'h8000_001C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_addr = '0;
    logic        io_re = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic        instr_commit = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;

    io_mmio_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_addr      (io_addr),
        .io_re        (io_re),
        .io_we        (io_we),
        .io_wdata     (io_wdata),
        .io_rdata     (io_rdata),
        .instr_commit (instr_commit),
`ifdef IO_BRANCH_STATS_EN
        .branch_commit(1'b0),
        .branch_taken (1'b0),
`endif
        .uart_rx_data (uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready),
        .uart_tx_data (uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int tb_cyc = 0;
    int clr_cyc = 0;
    int instr_model = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_tag_q[$];
    logic [7:0]  tx_exp_q[$];

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish (n_vec=%0d)", n_vec);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge: outputs settled, safe to drive.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read; expectation queued at issue, compared when data lands.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        io_addr = addr;
        io_re   = 1'b1;
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
        tick();
        io_re = 1'b0;
        check(rd_tag_q.pop_front(), io_rdata, rd_exp_q.pop_front());
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        io_addr  = addr;
        io_wdata = data;
        io_we    = 1'b1;
        tick();
        io_we = 1'b0;
    endtask

    // Expected CYCLE for a read issued now, relative to the last CNT_RST write.
    function automatic logic [31:0] cyc_exp();
        logic [CW-1:0] v;
        v = CW'(tb_cyc - clr_cyc - 1);
        return 32'(v);
    endfunction

    task automatic clear_counters();
        clr_cyc = tb_cyc;
        instr_model = 0;
        do_write(A_CNTRST, 32'h0);
    endtask

    // Let the transmitter drain; every presented byte must match the queue.
    task automatic drain_tx();
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 3 * TXD; i++) begin
            if (uart_tx_valid) begin
                if (tx_exp_q.size() == 0) check("tx_extra_byte", 32'(uart_tx_valid), 32'h0);
                else                      check("tx_byte", 32'(uart_tx_data), 32'(tx_exp_q.pop_front()));
            end
            tick();
        end
        uart_tx_ready = 1'b0;
        check("tx_left_in_model", 32'(tx_exp_q.size()), 32'h0);
        check("tx_idle", 32'(uart_tx_valid), 32'h0);
    endtask

    initial begin
        // ---- reset ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
        rst_n = 1'b1;
        tick();
        do_read(A_STATUS, 32'h1, "status_after_reset");

        // ---- RX path ----
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h41;
        tick();
        uart_rx_data  = 8'h42;
        tick();
        uart_rx_valid = 1'b0;
        do_read(A_STATUS, 32'h3, "status_rx_two");
        do_read(A_RXDATA, 32'h41, "rx_first");
        do_read(A_RXDATA, 32'h42, "rx_second");
        tick();
        check("rdata_hold", io_rdata, 32'h42);
        do_read(A_STATUS, 32'h1, "status_rx_drained");
        do_read(A_RXDATA, 32'h0, "rx_empty_read");
        // Underflow sets rx_ovf, which is STATUS bit3.
        do_read(A_STATUS, 32'h9, "status_rx_udf");
        do_write(A_STATUS, 32'hDEAD_BEEF);
        do_read(A_STATUS, 32'h1, "status_cleared");

        // RX fill to full: ready must drop, extra byte is not taken.
        uart_rx_valid = 1'b1;
        for (int i = 0; i <= RXD; i++) begin
            uart_rx_data = 8'(8'h60 + i);
            tick();
        end
        uart_rx_valid = 1'b0;
        check("rx_full_ready", 32'(uart_rx_ready), 32'h0);
        for (int i = 0; i < RXD; i++) do_read(A_RXDATA, 32'(8'h60 + i), "rx_full_drain");
        check("rx_ready_after_drain", 32'(uart_rx_ready), 32'h1);
        do_read(A_STATUS, 32'h1, "status_rx_full_done");

        // ---- TX overflow ----
        uart_tx_ready = 1'b0;
        for (int i = 0; i <= TXD; i++) begin
            if (tx_exp_q.size() < TXD) tx_exp_q.push_back(8'(i));
            do_write(A_TXDATA, 32'(i));
        end
        check("tx_head", 32'(uart_tx_data), 32'h0);
        do_read(A_STATUS, 32'h4, "status_tx_ovf");
        drain_tx();
        do_write(A_STATUS, 32'h0);
        do_read(A_STATUS, 32'h1, "status_tx_cleared");

        // ---- TX simultaneous push/pop while full: accepted, no overflow ----
        for (int i = 0; i < TXD; i++) begin
            tx_exp_q.push_back(8'(8'h10 + i));
            do_write(A_TXDATA, 32'(8'h10 + i));
        end
        uart_tx_ready = 1'b1;
        check("tx_head_full", 32'(uart_tx_data), 32'(tx_exp_q.pop_front()));
        tx_exp_q.push_back(8'h18);
        do_write(A_TXDATA, 32'h18);
        uart_tx_ready = 1'b0;
        do_read(A_STATUS, 32'h0, "status_full_no_ovf");
        drain_tx();

        // ---- counters ----
        instr_commit = 1'b1;
        clear_counters();
        instr_commit = 1'b0;
        do_read(A_INSTR, 32'h0, "instr_after_clr");
        do_read(A_CYCLE, 32'h1, "cycle_after_clr");

        clear_counters();
        for (int i = 0; i < 100; i++) begin
            instr_commit = (i % 5) < 2;
            if (instr_commit) instr_model++;
            tick();
        end
        instr_commit = 1'b0;
        do_read(A_INSTR, 32'(instr_model), "instr_40");
        do_read(A_CYCLE, cyc_exp(), "cycle_100");
        do_read(A_OFF3, 32'h0, "off3_zero");
        do_read(A_OFF7, 32'h0, "off7_zero");

        // ---- CYCLE wrap with CNT_W=8 ----
        clear_counters();
        repeat (255) tick();
        do_read(A_CYCLE, 32'hFF, "cycle_max");
        do_read(A_CYCLE, 32'h0, "cycle_wrap");
        do_read(A_INSTR, 32'h0, "instr_untouched");
        do_read(A_STATUS, 32'h1, "status_after_wrap");

        // ---- async reset mid-stream ----
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h77;
        tick();
        uart_rx_valid = 1'b0;
        do_write(A_TXDATA, 32'hA5);
        do_write(A_TXDATA, 32'h5A);
        check("pre_rst_tx_valid", 32'(uart_tx_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx_valid", 32'(uart_tx_valid), 32'h0);
        check("async_rst_rx_ready", 32'(uart_rx_ready), 32'h1);
        check("async_rst_rdata", io_rdata, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        do_read(A_STATUS, 32'h1, "status_after_midrst");
        do_read(A_RXDATA, 32'h0, "rx_empty_after_midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
